// File: rtl/fetch_stage_pkg.sv
// Shared fetch types: machine word, fetch entry carried from fetch to decode,
// and the default reset vector.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam word_t WORD_ALIGN_MASK      = 32'hFFFF_FFFC;

    typedef struct packed {
        word_t pc;
        word_t ir;
    } fetch_entry_t;

    function automatic word_t align_word(input word_t addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Response skid FIFO between the ROM read port and decode. Flush wins over
// push and pop; the head reads as zero while the FIFO is empty.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_q;
    logic [PTR_W-1:0]       wr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push_s;
    logic                   do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
    assign do_push_s = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop_s);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            rd_q    <= {PTR_W{1'b0}};
            wr_q    <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_q <= ptr_inc(wr_q);
            end
            if (do_pop_s) begin
                rd_q <= ptr_inc(rd_q);
            end
            count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i && do_push_s) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q == {CNT_W{1'b0}}) ? '0 : mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage_checker.sv
// Invariants of the fetch front end: the skid FIFO never overflows and every
// delivered pc is word aligned.
module fetch_stage_checker #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             valid_i,
    input  logic [1:0]       pc_lsb_i
);

    logic full_no_pop_s;

    assign full_no_pop_s = (count_i == CNT_W'(DEPTH)) & ~pop_i;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && !flush_i && full_no_pop_s))
        else $error("fetch buffer overflow");

    a_pc_aligned: assert property (@(posedge clk_i) disable iff (reset_i)
        valid_i |-> (pc_lsb_i == 2'b00))
        else $error("fetch pc misaligned");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: drives the ROM address, tracks the single
// in-flight read, and hands {pc, ir} pairs to decode through a skid FIFO.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int    FIFO_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_addr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    word_t              pc_q;
    word_t              pc_d;
    logic               inflight_q;
    logic               inflight_d;
    word_t              inflight_pc_q;
    word_t              inflight_pc_d;

    logic               pop_s;
    logic               push_s;
    logic               issue_s;
    logic [CNT_W-1:0]   count_s;
    logic [OCC_W-1:0]   occupancy_s;
    fetch_entry_t       head_s;
    fetch_entry_t       push_data_s;

    assign pop_s  = valid_o & ready_i;
    assign push_s = inflight_q & ~jmp_valid_i;

    // Credit: entries staying in the FIFO plus the read already in flight must leave room.
    assign occupancy_s = OCC_W'(count_s) - OCC_W'(pop_s) + OCC_W'(inflight_q);
    assign issue_s     = ~jmp_valid_i & (occupancy_s < OCC_W'(FIFO_DEPTH));

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (jmp_valid_i) begin
            pc_d = align_word(jmp_addr_i);
        end else if (issue_s) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= align_word(RESET_VECTOR);
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_data_s.pc = inflight_pc_q;
    assign push_data_s.ir = imem_data_i;

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (jmp_valid_i),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign imem_addr_o = pc_q;
    assign valid_o     = (count_s != {CNT_W{1'b0}});
    assign pc_o        = head_s.pc;
    assign ir_o        = head_s.ir;

endmodule
